pad_input_debouncer: RTL and testbench

//  Conditions the raw core-side values of input pad cells before core logic uses them.
//  - Synchronises each pad value into clk_i with an N-flop synchroniser.
//  - Applies a programmable glitch/debounce filter per pad.
//  - Produces the filtered level, one-cycle rise/fall pulses and sticky per-pad event flags.
//  - ORs the enabled event flags into one level interrupt.

---
 rtl/pad_input_pkg.sv | 13 +
 rtl/pad_input_filter_ch.sv | 115 +++++++++++
 rtl/pad_input_debouncer.sv | 71 +++++++
 tb/tb_pad_input_debouncer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pad_input_pkg.sv
// Shared types and limits for the input pad conditioning block.
// Debounce FSM encoding and synchroniser depth bounds.
package pad_input_pkg;

    typedef enum logic {
        DB_STABLE,
        DB_CHECK
    } db_state_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/pad_input_filter_ch.sv
// One pad channel: synchroniser, debounce FSM with saturating counter, edge pulses.
// Latency SYNC_STAGES + max(threshold,1) pad->value_o; pulses one cycle later; no backpressure.
// rise_evt_o/fall_evt_o flag the cycle in which rise_o/fall_o are being loaded.
module pad_input_filter_ch
    import pad_input_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 16,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pad_val_i,
    input  logic             filter_en_i,
    input  logic [CNT_W-1:0] debounce_cycles_i,
    output logic             value_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             rise_evt_o,
    output logic             fall_evt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   value_q, value_d;
    logic                   prev_q;
    logic [CNT_W:0]         cnt_inc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_val_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
            value_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
        end
    end

    // One extra bit so the threshold compare cannot overflow at all-ones.
    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        if (!filter_en_i) begin
            state_d = DB_STABLE;
            cnt_d   = '0;
            value_d = s;
        end else begin
            case (state_q)
                DB_STABLE: begin
                    cnt_d = '0;
                    if (s != value_q) begin
                        if (debounce_cycles_i <= CNT_W'(1)) begin
                            value_d = s;
                        end else begin
                            state_d = DB_CHECK;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                DB_CHECK: begin
                    if (s == value_q) begin
                        state_d = DB_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_inc >= {1'b0, debounce_cycles_i}) begin
                        state_d = DB_STABLE;
                        cnt_d   = '0;
                        value_d = s;
                    end else if (!(&cnt_q)) begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end
                default: begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // prev_q resets with value_q, so a reset never looks like a transition.
    assign rise_evt_o = value_q & ~prev_q;
    assign fall_evt_o = ~value_q & prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= RESET_VAL;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            prev_q <= value_q;
            rise_o <= rise_evt_o;
            fall_o <= fall_evt_o;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/pad_input_debouncer.sv
// Per-pad sync + debounce with edge pulses, sticky event flags and a level interrupt.
// Latency SYNC_STAGES + max(threshold,1) to value_o; pending with the pulse; irq_o one cycle later.
// No backpressure; pending flags hold until written 1 on clear_i.
module pad_input_debouncer
    import pad_input_pkg::*;
#(
    parameter int                  NUM_PADS    = 4,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  CNT_W       = 16,
    parameter logic [NUM_PADS-1:0] RESET_VAL   = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_PADS-1:0] pad_val_i,
    input  logic [NUM_PADS-1:0] filter_en_i,
    input  logic [CNT_W-1:0]    debounce_cycles_i,
    input  logic [NUM_PADS-1:0] rise_irq_en_i,
    input  logic [NUM_PADS-1:0] fall_irq_en_i,
    input  logic [NUM_PADS-1:0] clear_i,
    output logic [NUM_PADS-1:0] value_o,
    output logic [NUM_PADS-1:0] rise_o,
    output logic [NUM_PADS-1:0] fall_o,
    output logic [NUM_PADS-1:0] pending_o,
    output logic                irq_o
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_sync_range_err
        $error("pad_input_debouncer: SYNC_STAGES out of range 2..4");
    end

    logic [NUM_PADS-1:0] rise_evt;
    logic [NUM_PADS-1:0] fall_evt;
    logic [NUM_PADS-1:0] pending_q;
    logic                irq_q;

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_ch
        pad_input_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .RESET_VAL   (RESET_VAL[i])
        ) u_ch (
            .clk_i             (clk_i),
            .rst_i             (rst_i),
            .pad_val_i         (pad_val_i[i]),
            .filter_en_i       (filter_en_i[i]),
            .debounce_cycles_i (debounce_cycles_i),
            .value_o           (value_o[i]),
            .rise_o            (rise_o[i]),
            .fall_o            (fall_o[i]),
            .rise_evt_o        (rise_evt[i]),
            .fall_evt_o        (fall_evt[i])
        );
    end

    // Flags latch on the same edge that raises the pulse; a new event beats a clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~clear_i)
                       | (rise_evt & rise_irq_en_i)
                       | (fall_evt & fall_irq_en_i);
            irq_q     <= |pending_q;
        end
    end

    assign pending_o = pending_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_pad_input_debouncer.sv
// Directed, table-driven and random checks of pad_input_debouncer against a run-length reference model.
module tb_pad_input_debouncer;

    localparam int         NP  = 4;
    localparam int         SS  = 2;
    localparam int         CW  = 16;
    localparam logic [3:0] RV  = 4'b0101;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] pad, filt, ren, fen, clr;
    logic [CW-1:0] thr;
    logic [NP-1:0] value, rise, fall, pend;
    logic          irq;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [NP-1:0] hist[$];
    logic [NP-1:0] m_val, m_rise, m_fall, m_pend, m_chg_r, m_chg_f;
    logic          m_irq;
    int            m_run[NP];

    typedef struct {
        logic [NP-1:0] pad;
        logic [NP-1:0] filt;
        logic [CW-1:0] thr;
        logic [NP-1:0] exp_val;
        logic [NP-1:0] exp_rise;
        logic [NP-1:0] exp_fall;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    pad_input_debouncer #(
        .NUM_PADS(NP), .SYNC_STAGES(SS), .CNT_W(CW), .RESET_VAL(RV)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pad_val_i(pad), .filter_en_i(filt),
        .debounce_cycles_i(thr), .rise_irq_en_i(ren), .fall_irq_en_i(fen),
        .clear_i(clr), .value_o(value), .rise_o(rise), .fall_o(fall),
        .pending_o(pend), .irq_o(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Value flips once a pad's synchronised level has disagreed with it for
    // max(threshold,1) consecutive cycles; pulses and flags trail by one cycle.
    task automatic model_step();
        logic [NP-1:0] s, old;
        int lim;
        if (rst) begin
            hist.delete();
            for (int k = 0; k < SS; k++) hist.push_back(RV);
            m_val = RV; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
            m_chg_r = '0; m_chg_f = '0;
            for (int i = 0; i < NP; i++) m_run[i] = 0;
        end else begin
            m_irq  = |m_pend;
            m_pend = (m_pend & ~clr) | (m_chg_r & ren) | (m_chg_f & fen);
            m_rise = m_chg_r;
            m_fall = m_chg_f;
            s = hist.pop_front();
            hist.push_back(pad);
            old = m_val;
            lim = (int'(thr) < 1) ? 1 : int'(thr);
            for (int i = 0; i < NP; i++) begin
                if (!filt[i]) begin
                    m_val[i] = s[i];
                    m_run[i] = 0;
                end else if (s[i] != m_val[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= lim) begin
                        m_val[i] = s[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_chg_r = m_val & ~old;
            m_chg_f = ~m_val & old;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model_value",   32'(value), 32'(m_val));
        chk("model_rise",    32'(rise),  32'(m_rise));
        chk("model_fall",    32'(fall),  32'(m_fall));
        chk("model_pending", 32'(pend),  32'(m_pend));
        chk("model_irq",     32'(irq),   32'(m_irq));
    endtask

    initial begin
        tbl[0] = '{4'b0101, 4'b1011, 16'd0, 4'b0001, 4'b0000, 4'b0000};
        tbl[1] = '{4'b0101, 4'b1011, 16'd0, 4'b0001, 4'b0000, 4'b0000};
        tbl[2] = '{4'b0101, 4'b1011, 16'd0, 4'b0101, 4'b0000, 4'b0000};
        tbl[3] = '{4'b0001, 4'b1011, 16'd0, 4'b0101, 4'b0100, 4'b0000};
        tbl[4] = '{4'b0001, 4'b1011, 16'd0, 4'b0101, 4'b0000, 4'b0000};
        tbl[5] = '{4'b0001, 4'b1011, 16'd0, 4'b0001, 4'b0000, 4'b0000};
        tbl[6] = '{4'b0101, 4'b1011, 16'd0, 4'b0001, 4'b0000, 4'b0100};
        tbl[7] = '{4'b0101, 4'b1011, 16'd0, 4'b0001, 4'b0000, 4'b0000};
        tbl[8] = '{4'b0101, 4'b1011, 16'd0, 4'b0101, 4'b0000, 4'b0000};
        tbl[9] = '{4'b0101, 4'b1011, 16'd0, 4'b0101, 4'b0100, 4'b0000};

        rst = 1'b1; pad = '0; filt = 4'b1111; thr = 16'd4;
        ren = '0; fen = '0; clr = '0;
        #1;

        // reset state and first release: pads 0 and 2 fall 6 cycles later
        for (int n = 0; n < 3; n++) tick();
        chk("reset_value", 32'(value), 32'(4'b0101));
        chk("reset_flags", 32'({rise, fall, pend, irq}), 32'(0));
        rst = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 5) chk("release_hold", 32'(value), 32'(4'b0101));
            if (n == 6) chk("release_fall", 32'(value), 32'(4'b0000));
            if (n == 7) chk("release_fall_pulse", 32'(fall), 32'(4'b0101));
        end

        // pad0 rise with rise interrupt enabled
        ren = 4'b0001; pad = 4'b0001;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 5) chk("rise_early", 32'(value), 32'(4'b0000));
            if (n == 6) chk("rise_value", 32'(value), 32'(4'b0001));
            if (n == 6) chk("rise_pulse_pre", 32'(rise), 32'(4'b0000));
            if (n == 7) chk("rise_pulse", 32'(rise), 32'(4'b0001));
            if (n == 7) chk("rise_pending", 32'(pend), 32'(4'b0001));
            if (n == 7) chk("irq_lag", 32'(irq), 32'(0));
            if (n == 8) chk("rise_pulse_end", 32'(rise), 32'(4'b0000));
            if (n == 8) chk("irq_set", 32'(irq), 32'(1));
        end

        // 3-cycle glitch on pad1 is filtered out
        pad = 4'b0011;
        for (int n = 0; n < 3; n++) tick();
        pad = 4'b0001;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("glitch_value", 32'(value), 32'(4'b0001));
            chk("glitch_edges", 32'({rise[1], fall[1]}), 32'(0));
        end
        chk("glitch_pending", 32'(pend), 32'(4'b0001));

        // bypassed pad2 with threshold 0
        for (int r = 0; r < 10; r++) begin
            pad = tbl[r].pad; filt = tbl[r].filt; thr = tbl[r].thr;
            tick();
            chk($sformatf("tbl%0d_value", r), 32'(value), 32'(tbl[r].exp_val));
            chk($sformatf("tbl%0d_rise", r),  32'(rise),  32'(tbl[r].exp_rise));
            chk($sformatf("tbl%0d_fall", r),  32'(fall),  32'(tbl[r].exp_fall));
        end
        filt = 4'b1111; thr = 16'd4;

        // clear in the cycle a new rise latches: set wins, later clear drops it
        pad = 4'b0100;
        for (int n = 0; n < 10; n++) tick();
        chk("pre_clear_value", 32'(value), 32'(4'b0100));
        pad = 4'b0101;
        for (int n = 0; n < 6; n++) tick();
        clr = 4'b0001;
        tick();
        chk("set_wins_pending", 32'(pend), 32'(4'b0001));
        chk("set_wins_rise", 32'(rise), 32'(4'b0001));
        tick();
        chk("clear_pending", 32'(pend), 32'(4'b0000));
        chk("clear_irq_lag", 32'(irq), 32'(1));
        clr = '0;
        tick();
        chk("clear_irq_drop", 32'(irq), 32'(0));

        // reset in the middle of a count: no pulse afterwards
        pad = 4'b0100;
        for (int n = 0; n < 5; n++) tick();
        rst = 1'b1; pad = 4'b0101;
        tick();
        chk("midrst_value", 32'(value), 32'(4'b0101));
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            chk("midrst_no_pulse", 32'({rise, fall}), 32'(0));
        end

        // maximum threshold: counter runs to 0xFFFF without wrapping early
        thr = 16'hFFFF; pad = 4'b0100;
        for (int n = 1; n <= 65537; n++) begin
            tick();
            if (n == 65536) chk("max_thr_hold", 32'(value), 32'(4'b0101));
            if (n == 65537) chk("max_thr_update", 32'(value), 32'(4'b0100));
        end

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NP; i++)
                if ($urandom_range(0, 5) == 0) pad[i] = ~pad[i];
            if ($urandom_range(0, 40) == 0) filt = 4'($urandom);
            if ($urandom_range(0, 30) == 0) thr = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 20) == 0) ren = 4'($urandom);
            if ($urandom_range(0, 20) == 0) fen = 4'($urandom);
            clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
